// File: rtl/keypad_scanner_if.sv
// Key-matrix pins plus the debounced key-event bus of the whack-a-mole keypad scanner.
interface keypad_scanner_if;
    logic [2:0] key_matrix_row;
    logic [2:0] key_matrix_col;
    logic [8:0] key_pressed;
    logic       key_any;
    logic       key_valid;
    logic [3:0] key_index;

    // Scanner side: samples rows, drives columns and publishes key state/events.
    modport master (
        input  key_matrix_row,
        output key_matrix_col,
        output key_pressed,
        output key_any,
        output key_valid,
        output key_index
    );

    // Matrix/consumer side.
    modport slave (
        output key_matrix_row,
        input  key_matrix_col,
        input  key_pressed,
        input  key_any,
        input  key_valid,
        input  key_index
    );
endinterface

// File: rtl/keypad_scanner.sv
// 3x3 key matrix scanner: one-cold column drive, synchronized row sampling,
// whole-matrix frame debounce and a one-per-cycle queue of new-press events.
module keypad_scanner #(
    parameter int SCAN_TICKS     = 50_000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input logic              clk,
    input logic              reset,
    keypad_scanner_if.master kp
);
    localparam int TICK_W = $clog2(SCAN_TICKS);
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

    logic [2:0]        row_p0;
    logic [2:0]        row_p1;
    logic [2:0]        rows;
    logic [TICK_W-1:0] tick;
    logic [1:0]        col;
    logic [1:0]        col_next;
    logic [2:0]        col_drive;
    logic              last_tick;
    logic              frame_end;
    logic [8:0]        work_snap;
    logic [8:0]        snap;
    logic [8:0]        last_snap;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [8:0]        pressed;
    logic [8:0]        pressed_next;
    logic [8:0]        newly;
    logic [8:0]        pending;
    logic [8:0]        drain;
    logic              vld;
    logic [3:0]        index;

    // Stable-frame count saturates at the acceptance threshold.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(DEBOUNCE_SCANS)) ? v : v + CNT_W'(1);
    endfunction

    // Index of the lowest set bit; callers only use it when v is non-zero.
    function automatic logic [3:0] lowest_index(input logic [8:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    assign rows      = ~row_p1;
    assign last_tick = (tick == TICK_W'(SCAN_TICKS - 1));
    assign frame_end = last_tick && (col == 2'd2);
    assign col_next  = last_tick ? ((col == 2'd2) ? 2'd0 : col + 2'd1) : col;

    // Two-flop row synchronizer; idle lines read as released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_p0 <= 3'b111;
            row_p1 <= 3'b111;
        end else begin
            row_p0 <= kp.key_matrix_row;
            row_p1 <= row_p0;
        end
    end

    // Column sequencer; the drive register follows col_next so pins and col stay aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick      <= '0;
            col       <= 2'd0;
            col_drive <= 3'b110;
        end else begin
            tick      <= last_tick ? '0 : tick + TICK_W'(1);
            col       <= col_next;
            col_drive <= ~(3'b001 << col_next);
        end
    end

    // Working snapshot with this column's samples merged, plus debounce decisions.
    always_comb begin
        snap = work_snap;
        if (last_tick) begin
            case (col)
                2'd0: begin snap[0] = rows[0]; snap[3] = rows[1]; snap[6] = rows[2]; end
                2'd1: begin snap[1] = rows[0]; snap[4] = rows[1]; snap[7] = rows[2]; end
                2'd2: begin snap[2] = rows[0]; snap[5] = rows[1]; snap[8] = rows[2]; end
                default: ;
            endcase
        end
        cnt_next     = (snap != last_snap) ? CNT_W'(1) : sat_inc(cnt);
        pressed_next = pressed;
        if (frame_end && (cnt_next == CNT_W'(DEBOUNCE_SCANS))) pressed_next = snap;
        newly = pressed_next & ~pressed;
        drain = pending & (~pending + 9'd1);
    end

    // Snapshot capture and frame-end debounce state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_snap <= '0;
            last_snap <= '0;
            cnt       <= '0;
            pressed   <= '0;
        end else begin
            work_snap <= snap;
            pressed   <= pressed_next;
            if (frame_end) begin
                last_snap <= snap;
                cnt       <= cnt_next;
            end
        end
    end

    // Pending-press queue: drain the lowest index each cycle, merge new presses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            vld     <= 1'b0;
            index   <= 4'd0;
        end else begin
            pending <= (pending & ~drain) | newly;
            vld     <= |pending;
            if (|pending) index <= lowest_index(drain);
        end
    end

    assign kp.key_matrix_col = col_drive;
    assign kp.key_pressed    = pressed;
    assign kp.key_any        = |pressed;
    assign kp.key_valid      = vld;
    assign kp.key_index      = index;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: frame-level key matrix model, scoreboard of expected
// press events (index and cycle), monitor popping on every key_valid pulse.
module tb_keypad_scanner;
    localparam int ST    = 4;
    localparam int DB    = 2;
    localparam int FRAME = 3 * ST;

    typedef struct {
        int idx;
        int at;
    } ev_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] keys  = '0;
    int         cyc   = 0;
    int         tests = 0;
    int         fails = 0;

    ev_t        sb[$];
    logic [8:0] hist[$];
    logic [8:0] acc = '0;
    int         fr  = 0;

    always #5 clk = ~clk;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_TICKS    (ST),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kif)
    );

    // Physical matrix: a closed key pulls its row low while its column is driven low.
    function automatic logic [2:0] matrix_rows(input logic [8:0] k, input logic [2:0] cold);
        logic [2:0] r_out;
        r_out = 3'b111;
        for (int c = 0; c < 3; c++) begin
            if (!cold[c]) begin
                for (int r = 0; r < 3; r++) begin
                    if (k[3 * r + c]) r_out[r] = 1'b0;
                end
            end
        end
        return r_out;
    endfunction

    assign kif.key_matrix_row = matrix_rows(keys, kif.key_matrix_col);

    always @(posedge clk) begin
        if (reset) cyc = 0;
        else       cyc = cyc + 1;
    end

    function automatic logic [2:0] exp_col(input int n);
        case ((n / ST) % 3)
            0:       return 3'b110;
            1:       return 3'b101;
            default: return 3'b011;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: column sequencing every cycle, scoreboard pop on each event pulse.
    always @(negedge clk) begin
        if (!reset) begin
            check("col_drive", int'(kif.key_matrix_col), int'(exp_col(cyc)));
            if (kif.key_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", int'(kif.key_index), -1);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    check("event_index", int'(kif.key_index), e.idx);
                    check("event_cycle", cyc, e.at);
                end
            end
        end
    end

    task automatic model_reset();
        hist.delete();
        sb.delete();
        acc = '0;
        fr  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_valid",   int'(kif.key_valid),      0);
        check("rst_pressed", int'(kif.key_pressed),    0);
        check("rst_col",     int'(kif.key_matrix_col), 3'b110);
        check("rst_index",   int'(kif.key_index),      0);
        model_reset();
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    // Hold one key pattern for a full frame, then update the model at frame end.
    task automatic run_frame(input logic [8:0] k);
        int         guard;
        logic [8:0] new_acc;
        logic [8:0] newly;
        bit         stable;
        int         j;
        keys  = k;
        guard = 0;
        while (cyc != FRAME * (fr + 1) && guard < 4 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        #2;
        if (guard >= 4 * FRAME) check("frame_timeout", guard, FRAME);
        check("queue_drained", sb.size(), 0);
        hist.push_back(k);
        fr++;
        new_acc = acc;
        if (hist.size() >= DB) begin
            stable = 1'b1;
            for (int i = hist.size() - DB; i < hist.size(); i++) begin
                if (hist[i] != k) stable = 1'b0;
            end
            if (stable) new_acc = k;
        end
        newly = new_acc & ~acc;
        j = 0;
        for (int i = 0; i < 9; i++) begin
            if (newly[i]) begin
                sb.push_back('{idx: i, at: FRAME * fr + 1 + j});
                j++;
            end
        end
        acc = new_acc;
        check("key_pressed", int'(kif.key_pressed), int'(acc));
        check("key_any",     int'(kif.key_any),     int'(acc != 0));
    endtask

    initial begin
        logic [8:0] k;
        logic [8:0] prev;

        // Reset and idle scanning.
        do_reset();
        repeat (3) run_frame(9'h000);

        // Single press: key 5 (row 1, column 2).
        do_reset();
        repeat (3) run_frame(9'b000100000);
        run_frame(9'h000);
        run_frame(9'h000);

        // Bounce rejection on key 4, then a stable hold.
        do_reset();
        repeat (3) begin
            run_frame(9'b000010000);
            run_frame(9'h000);
        end
        repeat (2) run_frame(9'b000010000);
        run_frame(9'h000);

        // Simultaneous presses of keys 0, 4, 8.
        do_reset();
        repeat (3) run_frame(9'h111);
        run_frame(9'h000);

        // Hold, release and repress key 3.
        do_reset();
        repeat (10) run_frame(9'b000001000);
        repeat (3)  run_frame(9'h000);
        repeat (3)  run_frame(9'b000001000);

        // Reset while the simultaneous-press queue is draining.
        do_reset();
        repeat (2) run_frame(9'h111);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("middrain_valid",   int'(kif.key_valid),      0);
        check("middrain_pressed", int'(kif.key_pressed),    0);
        check("middrain_col",     int'(kif.key_matrix_col), 3'b110);
        check("middrain_left",    sb.size(),                2);
        model_reset();
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        repeat (3) run_frame(9'h111);
        run_frame(9'h000);

        // Randomized key patterns, biased towards holding the previous pattern.
        do_reset();
        prev = '0;
        repeat (40) begin
            if ($urandom_range(0, 2) == 0) k = 9'($urandom_range(0, 511));
            else                           k = prev;
            run_frame(k);
            prev = k;
        end
        run_frame(prev);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 3x3 whack-a-mole key matrix by driving one column low at a time and sampling the three row lines. Debounces the resulting 9-key snapshot and emits one single-cycle hit event per newly pressed key. It is the input-side counterpart of the light controller: key index `i` corresponds to `LEDR[i]`. It feeds the game FSM and hit-judging logic.

## Interface
- `SCAN_TICKS`, default 50_000: clk cycles each column is driven (1 ms at 50 MHz); must be ≥ 4.
- `DEBOUNCE_SCANS`, default 5: consecutive identical frames required before a snapshot is accepted; must be ≥ 1.
- `clk`  in  1  system clock (CLOCK_50).
- `reset`  in  1  asynchronous, active-high reset.
- `key_matrix_row`  in  3  row lines, active-low (pulled up, low = key closed on the driven column).
- `key_matrix_col`  out  3  column drive, active-low one-cold.
- `key_pressed`  out  9  debounced key state; bit `3*r+c` is set while the key at row r, column c is held.
- `key_any`  out  1  `|key_pressed`.
- `key_valid`  out  1  one-cycle pulse, one pulse per newly pressed key.
- `key_index`  out  4  index 0..8 of the key reported by `key_valid`; holds its last value otherwise.

## Operation
- Rows pass through a 2-flop synchronizer and are inverted internally (1 = closed).
- Column sequencer: `tick` counts 0..SCAN_TICKS-1. `col` cycles 0→1→2→0 and advances when `tick` wraps. `key_matrix_col = ~(3'b001 << col)`, registered.
- At `tick == SCAN_TICKS-1`, the synchronized rows are written into working snapshot bits `{6+c, 3+c, c}`.
- Frame end is `tick == SCAN_TICKS-1` with `col == 2`. The evaluated snapshot `snap` is the working snapshot with column-2 samples merged in the same cycle.
- Debounce at frame end:
  - If `snap != last_snap`, then `cnt <= 1`. Otherwise `cnt <= min(cnt+1, DEBOUNCE_SCANS)`.
  - Always `last_snap <= snap`.
  - If the new `cnt == DEBOUNCE_SCANS`, then `key_pressed <= snap`. Otherwise `key_pressed` is unchanged.
- Event queue: `newly = key_pressed_next & ~key_pressed`. Every cycle, `pending <= (pending & ~drain) | newly`.
  - `drain` is the lowest set bit of the current `pending`.
  - If `pending != 0`, then `key_valid <= 1` and `key_index <=` index of `drain`. Otherwise `key_valid <= 0`.
- Releases generate no events.
- A pending key released before it is drained is still reported.
- A bit already pending that becomes newly set again is merged, not duplicated.
- Simultaneous new presses are reported in ascending index order, one per cycle.

## Timing
- Reset values:
  - `key_matrix_col = 3'b110`, `tick = 0`, `col = 0`.
  - `key_pressed = 0`, `key_any = 0`.
  - `key_valid = 0`, `key_index = 0`.
  - `pending = 0`, `cnt = 0`, `last_snap = 0`, working snapshot = 0, synchronizer = all ones (released).
- Frame length is `3*SCAN_TICKS` cycles.
- Settling: sampling at the last tick of a column gives ≥ 1 cycle of margin after the synchronizer when `SCAN_TICKS ≥ 4`.
- Frame end at edge F:
  - `key_pressed` and `pending` are updated and visible after F.
  - The first `key_valid` is visible after edge F+1.
  - Key k of n simultaneous presses pulses at F+k.
- Worst-case press-to-event latency: `(DEBOUNCE_SCANS+1)*3*SCAN_TICKS + 4` cycles.
- A bounce that changes any snapshot bit restarts the debounce count for the whole matrix.
- Reset asserted mid-frame or mid-drain clears everything immediately. Queued events are discarded. Scanning restarts at column 0, tick 0 after deassertion.

## Test plan
All scenarios use `SCAN_TICKS=4`, `DEBOUNCE_SCANS=2`, so frame = 12 cycles.
- **Reset/scan:** hold `reset`, release, keep rows at 3'b111. Expect `key_matrix_col` to sequence 110 for 4 cycles, 101 for 4, 011 for 4, then repeat. `key_valid` never asserts and `key_pressed = 0`.
- **Single press:** pull row 1 low only while column 2 is driven, stable for 3 frames. Expect `key_pressed = 9'b000100000` at the end of the second frame. Expect exactly one `key_valid` pulse, one cycle later, with `key_index = 5`.
- **Bounce rejection:** toggle the key-4 press on alternate frames for 6 frames. Expect `key_pressed` to stay 0 and no `key_valid`. Then hold it for 2 frames: expect one event with `key_index = 4`.
- **Simultaneous presses:** keys 0, 4 and 8 close in the same frame and stay closed. Expect `key_valid` high for 3 consecutive cycles with indices 0, 4, 8, then low.
- **Hold/release/repress:** hold key 3 for 10 frames, then release for 3 frames, then press again. Expect exactly 2 events, both with `key_index = 3`. The release produces no event.
- **Reset mid-drain:** start the simultaneous-press case and assert `reset` the cycle after the first pulse. Expect `key_valid = 0`, `key_pressed = 0` and `key_matrix_col = 3'b110` immediately. No further pulses until fresh debounced presses.
